// File: rtl/mvu_pkg.sv
// Shared MVU job descriptor type and the field widths common to the dispatcher and mvutop.
package mvu_pkg;

    localparam int MVU_NMVU    = 8;
    localparam int MVU_BMVUA   = (MVU_NMVU > 1) ? $clog2(MVU_NMVU) : 1;
    localparam int MVU_BCNTDWN = 29;
    localparam int MVU_BPREC   = 6;

    typedef struct packed {
        logic                   any;
        logic [MVU_BMVUA-1:0]   mvu;
        logic [MVU_BCNTDWN-1:0] countdown;
        logic [MVU_BPREC-1:0]   wprec;
        logic [MVU_BPREC-1:0]   iprec;
        logic [MVU_BPREC-1:0]   oprec;
    } mvu_job_t;

endpackage

// File: rtl/mvu_job_fifo.sv
// Synchronous FIFO of MVU job descriptors; head is visible combinationally while not empty.
module mvu_job_fifo
    import mvu_pkg::*;
#(
    parameter  int QDEPTH = 4,
    localparam int AW     = $clog2(QDEPTH),
    localparam int CW     = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  mvu_job_t      i_data,
    input  logic          i_pop,
    output mvu_job_t      o_head,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count
);

    mvu_job_t        r_mem [QDEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(QDEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // NOTE: storage is not reset; only the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mvu_job_dispatcher.sv
// Queues MVU job descriptors and dispatches them in order to NMVU MVUs, either to a named unit or to
// the next idle unit in round-robin order; each MVU's busy window is timed locally from its countdown.
module mvu_job_dispatcher
    import mvu_pkg::*;
#(
    parameter  int NMVU    = MVU_NMVU,
    parameter  int QDEPTH  = 4,
    parameter  int BCNTDWN = MVU_BCNTDWN,
    parameter  int BPREC   = MVU_BPREC,
    localparam int BMVUA   = (NMVU > 1) ? $clog2(NMVU) : 1,
    localparam int BQCNT   = $clog2(QDEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic                    job_any,
    input  logic [BMVUA-1:0]        job_mvu,
    input  logic [BCNTDWN-1:0]      job_countdown,
    input  logic [BPREC-1:0]        job_wprec,
    input  logic [BPREC-1:0]        job_iprec,
    input  logic [BPREC-1:0]        job_oprec,
    output logic [NMVU-1:0]         start,
    output logic [NMVU*BCNTDWN-1:0] countdown,
    output logic [NMVU*BPREC-1:0]   wprecision,
    output logic [NMVU*BPREC-1:0]   iprecision,
    output logic [NMVU*BPREC-1:0]   oprecision,
    output logic [NMVU-1:0]         busy,
    output logic [NMVU-1:0]         done,
    output logic [BQCNT-1:0]        q_count
);

    mvu_job_t           w_job;
    mvu_job_t           w_head;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic [BQCNT-1:0]   w_count;

    logic [NMVU-1:0]    w_busy;
    logic [BMVUA-1:0]   r_rr_ptr;
    logic               w_pick_found;
    logic [BMVUA-1:0]   w_pick_idx;
    logic [BMVUA-1:0]   w_scan_idx;
    logic [BMVUA-1:0]   w_tgt;
    logic               w_dispatch;
    logic [BMVUA-1:0]   w_disp_idx;
    logic [BCNTDWN-1:0] w_disp_len;

    always_comb begin
        w_job           = '0;
        w_job.any       = job_any;
        w_job.mvu       = MVU_BMVUA'(job_mvu);
        w_job.countdown = MVU_BCNTDWN'(job_countdown);
        w_job.wprec     = MVU_BPREC'(job_wprec);
        w_job.iprec     = MVU_BPREC'(job_iprec);
        w_job.oprec     = MVU_BPREC'(job_oprec);
    end

    assign job_ready = !w_full;
    assign w_push    = job_valid && job_ready;
    assign q_count   = w_count;

    mvu_job_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_job),
        .i_pop   (w_dispatch),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // First idle MVU scanning from the round-robin pointer, wrapping modulo NMVU.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_scan_idx   = '0;
        for (int k = 0; k < NMVU; k++) begin
            w_scan_idx = BMVUA'((int'(r_rr_ptr) + k) % NMVU);
            if (!w_pick_found && !w_busy[w_scan_idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_scan_idx;
            end
        end
    end

    // Head of queue blocks everything behind it until its own target becomes eligible.
    always_comb begin
        w_tgt      = BMVUA'(w_head.mvu);
        w_dispatch = 1'b0;
        w_disp_idx = w_tgt;
        if (!w_empty) begin
            if (w_head.any) begin
                w_dispatch = w_pick_found;
                w_disp_idx = w_pick_idx;
            end else begin
                w_dispatch = !w_busy[w_tgt];
            end
        end
        w_disp_len = BCNTDWN'(w_head.countdown);
        if (w_disp_len == '0) begin
            w_disp_len = BCNTDWN'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_dispatch && w_head.any) begin
            r_rr_ptr <= BMVUA'((int'(w_pick_idx) + 1) % NMVU);
        end
    end

    for (genvar g = 0; g < NMVU; g++) begin : g_mvu
        logic               r_start;
        logic               r_busy;
        logic               r_done;
        logic [BCNTDWN-1:0] r_timer;
        logic [BCNTDWN-1:0] r_countdown;
        logic [BPREC-1:0]   r_wprec;
        logic [BPREC-1:0]   r_iprec;
        logic [BPREC-1:0]   r_oprec;
        logic               w_sel;

        assign w_sel = w_dispatch && (w_disp_idx == BMVUA'(g));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_start     <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b0;
                r_timer     <= '0;
                r_countdown <= '0;
                r_wprec     <= '0;
                r_iprec     <= '0;
                r_oprec     <= '0;
            end else begin
                r_start <= w_sel;
                r_done  <= 1'b0;
                if (w_sel) begin
                    r_busy      <= 1'b1;
                    r_timer     <= w_disp_len;
                    r_countdown <= BCNTDWN'(w_head.countdown);
                    r_wprec     <= BPREC'(w_head.wprec);
                    r_iprec     <= BPREC'(w_head.iprec);
                    r_oprec     <= BPREC'(w_head.oprec);
                end else if (r_busy) begin
                    if (r_timer == BCNTDWN'(1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
            end
        end

        assign w_busy[g]                          = r_busy;
        assign start[g]                           = r_start;
        assign done[g]                            = r_done;
        assign countdown[g*BCNTDWN +: BCNTDWN]    = r_countdown;
        assign wprecision[g*BPREC +: BPREC]       = r_wprec;
        assign iprecision[g*BPREC +: BPREC]       = r_iprec;
        assign oprecision[g*BPREC +: BPREC]       = r_oprec;
    end

    assign busy = w_busy;

endmodule

// File: tb/tb_mvu_job_dispatcher.sv
// Scoreboard bench: accepted jobs queue their expected start; a negedge monitor pops and checks them
// and runs an independent per-MVU busy/done model from the expected countdown.
module tb_mvu_job_dispatcher;

    localparam int NMVU    = 8;
    localparam int QDEPTH  = 4;
    localparam int BCNTDWN = 29;
    localparam int BPREC   = 6;
    localparam int BMVUA   = 3;
    localparam int BQCNT   = 3;

    logic                    clk;
    logic                    rst_n;
    logic                    job_valid;
    logic                    job_ready;
    logic                    job_any;
    logic [BMVUA-1:0]        job_mvu;
    logic [BCNTDWN-1:0]      job_countdown;
    logic [BPREC-1:0]        job_wprec;
    logic [BPREC-1:0]        job_iprec;
    logic [BPREC-1:0]        job_oprec;
    logic [NMVU-1:0]         start;
    logic [NMVU*BCNTDWN-1:0] countdown;
    logic [NMVU*BPREC-1:0]   wprecision;
    logic [NMVU*BPREC-1:0]   iprecision;
    logic [NMVU*BPREC-1:0]   oprecision;
    logic [NMVU-1:0]         busy;
    logic [NMVU-1:0]         done;
    logic [BQCNT-1:0]        q_count;

    mvu_job_dispatcher #(
        .NMVU    (NMVU),
        .QDEPTH  (QDEPTH),
        .BCNTDWN (BCNTDWN),
        .BPREC   (BPREC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_any       (job_any),
        .job_mvu       (job_mvu),
        .job_countdown (job_countdown),
        .job_wprec     (job_wprec),
        .job_iprec     (job_iprec),
        .job_oprec     (job_oprec),
        .start         (start),
        .countdown     (countdown),
        .wprecision    (wprecision),
        .iprecision    (iprecision),
        .oprecision    (oprecision),
        .busy          (busy),
        .done          (done),
        .q_count       (q_count)
    );

    typedef struct {
        int mvu;
        int cd;
        int w;
        int ip;
        int op;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   rem       [NMVU];
    bit   dexp      [NMVU];
    int   start_cyc [NMVU];
    int   start_cnt [NMVU];
    int   done_cyc  [NMVU];
    int   done_cnt  [NMVU];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Monitor: scoreboard for starts plus an independent busy/done model.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   nstart;
        if (!rst_n) begin
            for (int i = 0; i < NMVU; i++) begin
                rem[i]  = 0;
                dexp[i] = 1'b0;
            end
        end else begin
            cyc++;
            nstart = 0;
            for (int i = 0; i < NMVU; i++) begin
                if (start[i]) begin
                    nstart++;
                    start_cyc[i] = cyc;
                    start_cnt[i]++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL start_unexpected: start[%0d] at cycle %0d, none expected", i, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (i !== e.mvu) begin
                            errors++;
                            $display("FAIL start_mvu: got MVU %0d, expected MVU %0d", i, e.mvu);
                        end
                        checks++;
                        if (countdown[i*BCNTDWN +: BCNTDWN] !== BCNTDWN'(e.cd)) begin
                            errors++;
                            $display("FAIL cfg_countdown[%0d]: got %0d, expected %0d", i,
                                     countdown[i*BCNTDWN +: BCNTDWN], e.cd);
                        end
                        checks++;
                        if ({wprecision[i*BPREC +: BPREC], iprecision[i*BPREC +: BPREC], oprecision[i*BPREC +: BPREC]}
                            !== {BPREC'(e.w), BPREC'(e.ip), BPREC'(e.op)}) begin
                            errors++;
                            $display("FAIL cfg_prec[%0d]: got w/i/o %0d/%0d/%0d, expected %0d/%0d/%0d", i,
                                     wprecision[i*BPREC +: BPREC], iprecision[i*BPREC +: BPREC],
                                     oprecision[i*BPREC +: BPREC], e.w, e.ip, e.op);
                        end
                        rem[i] = (e.cd == 0) ? 1 : e.cd;
                    end
                end
                checks++;
                if (busy[i] !== (rem[i] > 0)) begin
                    errors++;
                    $display("FAIL busy[%0d] cycle %0d: got %0b, expected %0b", i, cyc, busy[i], rem[i] > 0);
                end
                checks++;
                if (done[i] !== dexp[i]) begin
                    errors++;
                    $display("FAIL done[%0d] cycle %0d: got %0b, expected %0b", i, cyc, done[i], dexp[i]);
                end
                if (done[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                end
                dexp[i] = (rem[i] == 1);
                if (rem[i] > 0) rem[i]--;
            end
            checks++;
            if (nstart > 1) begin
                errors++;
                $display("FAIL start_multi: %0d starts in cycle %0d, expected at most 1", nstart, cyc);
            end
        end
    end

    task automatic clear_stats();
        exp_q.delete();
        for (int i = 0; i < NMVU; i++) begin
            start_cyc[i] = -1;
            start_cnt[i] = 0;
            done_cyc[i]  = -1;
            done_cnt[i]  = 0;
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        job_valid = 1'b0;
        clear_stats();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns the cycle stamp of the accepting edge.
    task automatic push_job(input bit any, input int mvu, input int cd, input int w, input int ip,
                            input int op, input int exp_mvu, output int acc);
        bit   ok;
        bit   rdy;
        exp_t e;
        ok            = 1'b0;
        acc           = -1;
        job_valid     = 1'b1;
        job_any       = any;
        job_mvu       = BMVUA'(mvu);
        job_countdown = BCNTDWN'(cd);
        job_wprec     = BPREC'(w);
        job_iprec     = BPREC'(ip);
        job_oprec     = BPREC'(op);
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            rdy = job_ready;
            @(posedge clk);
            if (rdy) ok = 1'b1;
        end
        #1;
        job_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_timeout: job for MVU %0d not accepted within 400 cycles", exp_mvu);
        end else begin
            acc   = cyc;
            e.mvu = exp_mvu;
            e.cd  = cd;
            e.w   = w;
            e.ip  = ip;
            e.op  = op;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && busy == '0 && done == '0 && q_count == '0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_drain: not idle after %0d cycles (pending starts %0d, busy %b)",
                     name, budget, exp_q.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int a;
        int b;
        apply_reset();
        checks++;
        if ({job_ready, q_count, busy, start, done} !== {1'b1, {BQCNT{1'b0}}, {3*NMVU{1'b0}}}) begin
            errors++;
            $display("FAIL reset_idle: ready=%0b q=%0d busy=%b start=%b done=%b, expected ready=1 rest 0",
                     job_ready, q_count, busy, start, done);
        end
        push_job(1'b0, 6, 30, 1, 2, 3, 6, a);
        push_job(1'b0, 6, 4, 1, 2, 3, 6, b);
        push_job(1'b0, 6, 4, 1, 2, 3, 6, b);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy[6], q_count} !== {1'b1, BQCNT'(2)}) begin
            errors++;
            $display("FAIL reset_pre: busy6=%0b q=%0d, expected busy6=1 q=2", busy[6], q_count);
        end
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({job_ready, q_count, busy, start, done} !== {1'b1, {BQCNT{1'b0}}, {3*NMVU{1'b0}}}) begin
            errors++;
            $display("FAIL reset_async: ready=%0b q=%0d busy=%b start=%b done=%b, expected ready=1 rest 0",
                     job_ready, q_count, busy, start, done);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if ({done_cnt[6], start_cnt[6]} !== {32'd0, 32'd1}) begin
            errors++;
            $display("FAIL reset_drop: done6 count=%0d starts6=%0d, expected 0 and 1", done_cnt[6], start_cnt[6]);
        end
    endtask

    task automatic test_targeted();
        int a;
        apply_reset();
        push_job(1'b0, 3, 5, 4, 2, 8, 3, a);
        wait_drain(50, "targeted");
        checks++;
        if (start_cyc[3] !== a + 2) begin
            errors++;
            $display("FAIL targeted_start: start cycle %0d, expected %0d", start_cyc[3], a + 2);
        end
        checks++;
        if ({done_cnt[3], done_cyc[3]} !== {32'd1, 32'(a + 7)}) begin
            errors++;
            $display("FAIL targeted_done: count %0d at cycle %0d, expected 1 at %0d", done_cnt[3], done_cyc[3], a + 7);
        end
        checks++;
        if (countdown[3*BCNTDWN +: BCNTDWN] !== BCNTDWN'(5)) begin
            errors++;
            $display("FAIL targeted_hold: countdown[3]=%0d, expected 5", countdown[3*BCNTDWN +: BCNTDWN]);
        end
    endtask

    task automatic test_round_robin();
        int a0;
        int a;
        apply_reset();
        push_job(1'b1, 7, 10, 1, 1, 1, 0, a0);
        for (int k = 1; k < 5; k++) push_job(1'b1, 7, 10, k, k + 1, k + 2, k, a);
        wait_drain(80, "round_robin");
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (start_cyc[k] !== a0 + 2 + k) begin
                errors++;
                $display("FAIL rr_start[%0d]: cycle %0d, expected %0d", k, start_cyc[k], a0 + 2 + k);
            end
        end
    endtask

    task automatic test_head_block();
        int a;
        int b;
        apply_reset();
        push_job(1'b0, 2, 6, 3, 3, 3, 2, a);
        push_job(1'b0, 2, 3, 5, 5, 5, 2, b);
        push_job(1'b1, 5, 4, 7, 7, 7, 0, b);
        wait_drain(80, "head_block");
        checks++;
        if ({start_cnt[2], start_cyc[2]} !== {32'd2, 32'(a + 9)}) begin
            errors++;
            $display("FAIL block_target: MVU2 starts %0d last at %0d, expected 2 last at %0d",
                     start_cnt[2], start_cyc[2], a + 9);
        end
        checks++;
        if (start_cyc[0] !== a + 10) begin
            errors++;
            $display("FAIL block_any: MVU0 start at %0d, expected %0d", start_cyc[0], a + 10);
        end
    endtask

    task automatic test_full();
        int a;
        int b;
        int c;
        apply_reset();
        push_job(1'b0, 1, 40, 2, 2, 2, 1, a);
        for (int k = 0; k < QDEPTH; k++) push_job(1'b0, 1, 2, k, k, k, 1, b);
        checks++;
        if ({q_count, job_ready} !== {BQCNT'(QDEPTH), 1'b0}) begin
            errors++;
            $display("FAIL full_state: q=%0d ready=%0b, expected q=%0d ready=0", q_count, job_ready, QDEPTH);
        end
        push_job(1'b0, 1, 2, 9, 9, 9, 1, c);
        checks++;
        if (c !== a + 43) begin
            errors++;
            $display("FAIL full_accept: held job accepted at %0d, expected %0d", c, a + 43);
        end
        wait_drain(100, "full");
        checks++;
        if (start_cnt[1] !== 6) begin
            errors++;
            $display("FAIL full_noloss: MVU1 starts %0d, expected 6", start_cnt[1]);
        end
    endtask

    task automatic test_zero_countdown();
        int a;
        int b;
        apply_reset();
        push_job(1'b0, 5, 0, 6, 6, 6, 5, a);
        push_job(1'b0, 5, 0, 1, 3, 5, 5, b);
        wait_drain(30, "zero_cd");
        checks++;
        if (start_cyc[5] !== a + 4) begin
            errors++;
            $display("FAIL zero_b2b: second start at %0d, expected %0d", start_cyc[5], a + 4);
        end
        checks++;
        if ({done_cnt[5], done_cyc[5]} !== {32'd2, 32'(a + 5)}) begin
            errors++;
            $display("FAIL zero_done: count %0d last at %0d, expected 2 last at %0d", done_cnt[5], done_cyc[5], a + 5);
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        job_valid     = 1'b0;
        job_any       = 1'b0;
        job_mvu       = '0;
        job_countdown = '0;
        job_wprec     = '0;
        job_iprec     = '0;
        job_oprec     = '0;
        clear_stats();
        #1;
        test_reset();
        test_targeted();
        test_round_robin();
        test_head_block();
        test_full();
        test_zero_countdown();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
